// File: rtl/aes_stress_monitor.sv
`default_nettype none
// ============================================================================
// Module   : aes_stress_monitor
// Purpose  : Result-side monitor for the AES-128 stress harness. Tracks the
//            encrypt core's start/finish handshake and folds every finished
//            ciphertext into a 128-bit MISR signature. Counts absorbed blocks
//            and raises done after NUM_BLOCKS of them. Protocol errors are
//            flagged, and optionally so are hung operations.
// Config   : `define AES_STRESS_MONITOR_TIMEOUT_EN enables the start->finish
//            watchdog timer and the timeout output. Without it, timeout is
//            tied to 0 and WAIT waits indefinitely.
// Ports    : clk          - sole clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - pulse, core accepted a new block
//            finish       - pulse, result valid this cycle
//            result[127:0]- ciphertext from the core
//            signature    - current MISR value
//            block_count  - number of absorbed results
//            busy         - operation outstanding
//            done         - sticky, NUM_BLOCKS results absorbed
//            err          - sticky, protocol error or timeout
//            timeout      - sticky, the error was a timeout
// Revision : 1.0 - initial release
// ============================================================================
module aes_stress_monitor #(
  parameter int          NUM_BLOCKS     = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [127:0] SEED          = 128'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         finish,
  input  logic [127:0] result,
  output logic [127:0] signature,
  output logic [15:0]  block_count,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [15:0] NB = 16'(NUM_BLOCKS);

  state_t         state;
  logic [127:0]   misr_next;
  logic [15:0]    count_inc;

  // Galois MISR step: multiply by x modulo x^128+x^7+x^2+x+1, then fold in
  // the new ciphertext.
  assign misr_next = {signature[126:0], 1'b0}
                   ^ (signature[127] ? 128'h87 : 128'h0)
                   ^ result;
  assign count_inc = block_count + 16'd1;

`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      signature   <= SEED;
      block_count <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
      timer       <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A finish with nothing outstanding is spurious, even if a start
          // arrives alongside it.
          if (finish) begin
            state <= ERROR;
            err   <= 1'b1;
          end else if (start) begin
            state <= WAIT;
            busy  <= 1'b1;
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
            timer <= '0;
`endif
          end
        end
        WAIT: begin
          if (finish) begin
            // finish always wins, including in the timer's expiry cycle
            signature   <= misr_next;
            block_count <= count_inc;
            if (count_inc == NB) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (start) begin
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
              timer <= '0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (start) begin
            state <= ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
            if (timer == TLAST) begin
              state   <= ERROR;
              err     <= 1'b1;
              timeout <= 1'b1;
              busy    <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
`endif
          end
        end
        default: begin
          // DONE and ERROR are terminal: everything frozen until reset.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_stress_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stress_monitor
// Purpose  : Self-checking bench for aes_stress_monitor. Two instances with
//            different SEED/NUM_BLOCKS share one stimulus stream; each is
//            compared every cycle against a behavioural model of the
//            handshake and signature. Honours AES_STRESS_MONITOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_stress_monitor;

  localparam int           TC     = 4;
  localparam int           NB_A   = 6;
  localparam int           NB_B   = 2;
  localparam logic [127:0] SEED_A = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] SEED_B = 128'h0;

  localparam int S_IDLE = 0, S_WAIT = 1, S_DONE = 2, S_ERR = 3;

  typedef struct {
    int           st;
    logic [127:0] sig;
    int           cnt;
    int           tmr;
    bit           tmo;
  } mdl_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         finish = 1'b0;
  logic [127:0] result = '0;

  logic [127:0] sig_a, sig_b;
  logic [15:0]  cnt_a, cnt_b;
  logic         busy_a, busy_b, done_a, done_b, err_a, err_b, to_a, to_b;

  int n_checks = 0;
  int n_pass   = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  aes_stress_monitor #(.NUM_BLOCKS(NB_A), .TIMEOUT_CYCLES(TC), .SEED(SEED_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .result(result),
    .signature(sig_a), .block_count(cnt_a), .busy(busy_a), .done(done_a),
    .err(err_a), .timeout(to_a)
  );

  aes_stress_monitor #(.NUM_BLOCKS(NB_B), .TIMEOUT_CYCLES(TC), .SEED(SEED_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .result(result),
    .signature(sig_b), .block_count(cnt_b), .busy(busy_b), .done(done_b),
    .err(err_b), .timeout(to_b)
  );

  // ---------------- reference model ----------------
  // Signature as a GF(2^128) element: each absorb multiplies by x, then adds
  // the ciphertext.
  function automatic logic [127:0] gf_mul_x(logic [127:0] a);
    logic [128:0] wide;
    wide = {a, 1'b0};
    if (wide[128]) wide = wide ^ {1'b1, 120'h0, 8'h87};
    return wide[127:0];
  endfunction

  function automatic mdl_t mreset(logic [127:0] seed);
    mdl_t m;
    m.st = S_IDLE; m.sig = seed; m.cnt = 0; m.tmr = 0; m.tmo = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit s, bit f, logic [127:0] r, int nb);
    mdl_t n = m;
    if (m.st == S_IDLE) begin
      if (f) n.st = S_ERR;
      else if (s) begin n.st = S_WAIT; n.tmr = 0; end
    end else if (m.st == S_WAIT) begin
      if (f) begin
        n.sig = gf_mul_x(m.sig) ^ r;
        n.cnt = m.cnt + 1;
        if (n.cnt == nb) n.st = S_DONE;
        else if (s) n.tmr = 0;
        else n.st = S_IDLE;
      end else if (s) begin
        n.st = S_ERR;
      end else begin
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
        // cycles spent waiting since start; TC of them without finish expire
        n.tmr = m.tmr + 1;
        if (n.tmr == TC) begin n.st = S_ERR; n.tmo = 1'b1; end
`endif
      end
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_dut(input string tag, input mdl_t m, input logic [127:0] sig,
                           input logic [15:0] cnt, input logic bsy, input logic dn,
                           input logic er, input logic to);
    check({tag, ".sig"},  sig,         m.sig);
    check({tag, ".cnt"},  128'(cnt),   128'(m.cnt));
    check({tag, ".busy"}, 128'(bsy),   128'(m.st == S_WAIT));
    check({tag, ".done"}, 128'(dn),    128'(m.st == S_DONE));
    check({tag, ".err"},  128'(er),    128'(m.st == S_ERR));
    check({tag, ".to"},   128'(to),    128'(m.tmo));
  endtask

  task automatic check_both(input string tag);
    check_dut({tag, ".a"}, ma, sig_a, cnt_a, busy_a, done_a, err_a, to_a);
    check_dut({tag, ".b"}, mb, sig_b, cnt_b, busy_b, done_b, err_b, to_b);
  endtask

  // one clock: drive at negedge, model steps at posedge, compare 1 unit later
  task automatic drive(input bit s, input bit f, input logic [127:0] r, input string tag);
    @(negedge clk);
    start = s; finish = f; result = r;
    @(posedge clk);
    ma = mstep(ma, s, f, r, NB_A);
    mb = mstep(mb, s, f, r, NB_B);
    #1;
    check_both(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; result = '0;
    ma = mreset(SEED_A);
    mb = mreset(SEED_B);
    #1;
    check_both("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // feedback tap: SEED_A has only the MSB set, result 0 -> 0x87
    drive(1'b1, 1'b0, '0, "tap.s");
    drive(1'b0, 1'b1, '0, "tap.f");
    check("tap.sig", sig_a, 128'h87);

    // basic absorb on dut_b (SEED 0, NUM_BLOCKS 2)
    do_reset();
    drive(1'b1, 1'b0, '0, "basic.s1");
    drive(1'b0, 1'b1, 128'h1, "basic.f1");
    check("basic.sig1", sig_b, 128'h1);
    drive(1'b1, 1'b0, '0, "basic.s2");
    drive(1'b0, 1'b1, 128'h2, "basic.f2");
    check("basic.sig2", sig_b, 128'h0);
    check("basic.cnt",  128'(cnt_b),  128'd2);
    check("basic.done", 128'(done_b), 128'd1);
    check("basic.busy", 128'(busy_b), 128'd0);

    // back-to-back start+finish in WAIT
    do_reset();
    drive(1'b1, 1'b0, '0, "b2b.s");
    drive(1'b1, 1'b1, rnd128(), "b2b.sf");
    check("b2b.busy", 128'(busy_a), 128'd1);
    drive(1'b0, 1'b1, rnd128(), "b2b.f");
    check("b2b.cnt", 128'(cnt_a), 128'd2);
    check("b2b.err", 128'(err_a), 128'd0);

    // spurious finish in IDLE, then junk must not disturb the frozen state
    do_reset();
    drive(1'b0, 1'b1, rnd128(), "perrA");
    check("perrA.err", 128'(err_a), 128'd1);
    check("perrA.to",  128'(to_a),  128'd0);
    check("perrA.sig", sig_a, SEED_A);
    for (int i = 0; i < 6; i++) drive(1'($urandom), 1'($urandom), rnd128(), "perrA.junk");
    check("perrA.cnt", 128'(cnt_a), 128'd0);

    // overlapping start
    do_reset();
    drive(1'b1, 1'b0, '0, "perrB.s1");
    drive(1'b1, 1'b0, '0, "perrB.s2");
    check("perrB.err", 128'(err_a), 128'd1);
    for (int i = 0; i < 6; i++) drive(1'($urandom), 1'($urandom), rnd128(), "perrB.junk");

    // timeout
    do_reset();
    drive(1'b1, 1'b0, '0, "tmo.s");
`ifdef AES_STRESS_MONITOR_TIMEOUT_EN
    for (int i = 1; i < TC; i++) begin
      drive(1'b0, 1'b0, '0, "tmo.w");
      check("tmo.early", 128'(err_a), 128'd0);
    end
    drive(1'b0, 1'b0, '0, "tmo.exp");
    check("tmo.err", 128'(err_a), 128'd1);
    check("tmo.to",  128'(to_a),  128'd1);
`else
    for (int i = 0; i < 1000; i++) drive(1'b0, 1'b0, '0, "tmo.w");
    check("tmo.err",  128'(err_a),  128'd0);
    check("tmo.busy", 128'(busy_a), 128'd1);
`endif

    // finish in the expiry cycle wins
    do_reset();
    drive(1'b1, 1'b0, '0, "tmoB.s");
    for (int i = 1; i < TC; i++) drive(1'b0, 1'b0, '0, "tmoB.w");
    drive(1'b0, 1'b1, rnd128(), "tmoB.f");
    check("tmoB.cnt", 128'(cnt_a), 128'd1);
    check("tmoB.err", 128'(err_a), 128'd0);

    // asynchronous reset while in WAIT with 5 blocks absorbed
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, '0, "mid.s");
      drive(1'b0, 1'b1, rnd128(), "mid.f");
    end
    drive(1'b1, 1'b0, '0, "mid.s6");
    check("mid.cnt5", 128'(cnt_a), 128'd5);
    #2;
    rst_n = 1'b0;
    ma = mreset(SEED_A);
    mb = mreset(SEED_B);
    #1;
    check_both("mid.async");
    check("mid.sig0", sig_a, SEED_A);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0; finish = 1'b0;
    drive(1'b1, 1'b0, '0, "mid.s1");
    drive(1'b0, 1'b1, rnd128(), "mid.f1");
    check("mid.cnt1", 128'(cnt_a), 128'd1);

    // randomized runs, biased towards the harness pattern
    for (int run = 0; run < 20; run++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        int p;
        bit s, f;
        p = $urandom_range(0, 99);
        s = 1'b0; f = 1'b0;
        if (ma.st == S_IDLE) begin
          if (p < 80) s = 1'b1;
          else if (p < 83) f = 1'b1;
        end else if (ma.st == S_WAIT) begin
          if (p < 25) begin f = 1'b1; s = 1'b1; end
          else if (p < 65) f = 1'b1;
          else if (p < 69) s = 1'b1;
        end else begin
          s = 1'($urandom); f = 1'($urandom);
        end
        drive(s, f, rnd128(), "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
